fir_inverse: RTL and testbench
==============================

# fir_inverse

Inverse (deconvolution) filter for the fixed 4-tap FIR path, with coefficients h = [1, 2, 3, 4]. It takes a stream of 16-bit FIR output samples y[n] and recovers the 8-bit input samples using x[n] = y[n] − 2·x[n−1] − 3·x[n−2] − 4·x[n−3]. It sits at the receive end of the filter link and is used to check or undo the FIR on the far side. Arithmetic is serial: one multiply-accumulate per cycle, with valid/ready handshakes on both sides.

## Interface
- N, default 4: tap count. Coefficients are fixed at h[k] = k+1, and h[0] = 1 is required.
- DW, default 8: recovered sample width (signed).
- YW, default 16: input sample width (signed).
- AW, default 18: accumulator width (signed).
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: y_in is valid.
- in_ready, output, 1: block can accept a sample.
- y_in, input, YW: FIR output sample y[n], signed.
- out_valid, output, 1: x_out holds a recovered sample.
- out_ready, input, 1: downstream accepts x_out.
- x_out, output, DW: recovered sample x[n], signed, saturated.
- sat_clr, input, 1: synchronous clear of sat_flag.
- sat_flag, output, 1: sticky flag; set when any recovered sample saturated.

## Operation
- States:
  - IDLE: in_ready=1.
  - MAC: runs tap index k = 1..N−1.
  - OUT: out_valid=1.
- Reset values:
  - state IDLE, k=0, acc=0.
  - History hist[0..N−2]=0.
  - x_out=0, out_valid=0, sat_flag=0.
  - in_ready=0 while rst is high.
- IDLE:
  - On in_valid & in_ready, acc ← sign-extend(y_in) to AW, k ← 1, go to MAC.
  - Otherwise stay in IDLE.
- MAC, per cycle:
  - Term = h[k]·hist[k−1], where hist[0] = x[n−1].
  - If k < N−1: acc ← acc − term, k ← k+1.
  - If k = N−1: compute final = acc − term combinationally.
    - x_out ← sat(final).
    - hist shifts: hist[j] ← hist[j−1], hist[0] ← sat(final).
    - out_valid ← 1, go to OUT.
- Saturation:
  - sat() clamps to [−2^(DW−1), 2^(DW−1)−1], i.e. [−128, 127].
  - If clamping occurs, sat_flag ← 1.
  - The saturated value, not the raw one, enters the history.
- OUT:
  - x_out and out_valid are held stable until out_ready=1.
  - On that edge: out_valid ← 0, go to IDLE.
- in_ready = (state == IDLE) & ~rst.
  - in_valid outside IDLE is ignored; no sample is captured.
  - The upstream source must hold y_in until it is accepted.
- sat_flag: if a saturation set and sat_clr occur on the same edge, the set wins.
- Width rules:
  - Largest magnitude is |y| + (2+3+4)·128, which fits in 17 bits, so AW=18 has no overflow.
  - Products are DW+3 bits, signed.
- Reset mid-operation:
  - Asynchronously returns to IDLE, clears the history, drops out_valid.
  - Any partial sample is discarded.
- The history reflects only samples that completed MAC. It advances on result registration, not on the output handshake.

## Timing
- Accept edge T0. MAC occupies the edges T1 … T(N−1).
- out_valid rises after edge T(N−1): 3 cycles after accept for N=4.
- Output handshake no earlier than edge T(N), then IDLE for 1 cycle.
- With out_ready tied high, next accept is at T(N+1): 1 sample per N+1 = 5 cycles.
- Backpressure: OUT is held indefinitely. No sample is lost or duplicated.
- No combinational path from in_valid or out_ready to any output.

## Test plan
- Impulse:
  - Stimulus: y = 1, 2, 3, 4 after reset, out_ready high.
  - Required: x_out = 1, 0, 0, 0; sat_flag=0; each out_valid 3 cycles after its accept.
- Mixed sequence:
  - Stimulus: y = 10, 15, 147, 151, i.e. the FIR of x = 10, −5, 127, −128.
  - Required: x_out = 10, −5, 127, −128; sat_flag=0.
- Saturation:
  - Stimulus: y = 300 after reset.
  - Required: x_out=127, sat_flag=1.
  - Follow with y=0: x_out = sat(−254) = −128.
  - Then pulse sat_clr: sat_flag=0 on the next cycle.
- Backpressure:
  - Stimulus: hold out_ready low for 10 cycles during OUT and pulse in_valid.
  - Required: x_out and out_valid stable, in_ready=0, no extra samples.
  - On release: exactly one handshake, then in_ready=1 one cycle later.
- Reset mid-MAC:
  - Stimulus: assert rst at T2 of a sample.
  - Required: out_valid=0 and in_ready=0 immediately; after release, in_ready=1.
  - Then feed y=5: x_out=5, since the history was cleared.
- Throughput:
  - Stimulus: in_valid and out_ready held high for 8 samples.
  - Required: accepts exactly 5 cycles apart; outputs match the golden inverse-recursion model.

Source files
------------

// File: rtl/fir_inverse.sv
// Inverse of the fixed FIR h[k]=k+1: recovers x[n] = y[n] - sum_{k>=1} h[k]*x[n-k], saturated to DW bits.
// Latency: out_valid rises N-1 cycles after the accept edge; one sample every N+1 cycles at full rate.
// Backpressure: result is held in OUT until out_ready; in_ready is low outside IDLE, so nothing is captured meanwhile.
module fir_inverse #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int YW = 16,
  parameter int AW = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [YW-1:0] y_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] x_out,
  input  logic                 sat_clr,
  output logic                 sat_flag
);

  // Tap index must reach N-1; coefficients k+1 are kept positive in a signed field.
  localparam int KW = (N > 2) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1) + 1;
  localparam int PW = DW + CW;

  localparam logic signed [AW-1:0] SAT_MAX = (AW'(1) << (DW - 1)) - AW'(1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]  hist_q [0:N-2];
  logic signed [DW-1:0]  hist_d [0:N-2];
  logic signed [DW-1:0]  x_out_q, x_out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sat_flag_q, sat_flag_d;

  logic signed [DW-1:0]  hist_sel;
  logic [CW-1:0]         coef_u;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  term;
  logic signed [AW-1:0]  final_v;
  logic signed [AW-1:0]  y_ext;
  logic                  clamp_hi;
  logic                  clamp_lo;
  logic signed [DW-1:0]  sat_val;
  logic                  sat_set;

  // Datapath for the current tap: select x[n-k], multiply by h[k]=k+1, subtract, clamp.
  always_comb begin
    hist_sel = '0;
    for (int j = 0; j < N - 1; j++) begin
      if (k_q == KW'(j + 1)) begin
        hist_sel = hist_q[j];
      end
    end
    coef_u   = CW'(k_q) + CW'(1);
    prod     = $signed(coef_u) * hist_sel;
    term     = AW'(prod);
    final_v  = acc_q - term;
    y_ext    = AW'(y_in);
    clamp_hi = (final_v > SAT_MAX);
    clamp_lo = (final_v < SAT_MIN);
    if (clamp_hi) begin
      sat_val = SAT_MAX[DW-1:0];
    end else if (clamp_lo) begin
      sat_val = SAT_MIN[DW-1:0];
    end else begin
      sat_val = final_v[DW-1:0];
    end
  end

  // Next-state logic: accept in IDLE, one MAC per cycle, hold the result in OUT.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    hist_d      = hist_q;
    x_out_d     = x_out_q;
    out_valid_d = out_valid_q;
    sat_set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = y_ext;
          k_d     = KW'(1);
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        if (k_q == KW'(N - 1)) begin
          // Last tap: register the saturated result and push it into the history.
          x_out_d   = sat_val;
          hist_d[0] = sat_val;
          for (int j = 1; j < N - 1; j++) begin
            hist_d[j] = hist_q[j-1];
          end
          sat_set     = clamp_hi | clamp_lo;
          out_valid_d = 1'b1;
          k_d         = '0;
          state_d     = ST_OUT;
        end else begin
          acc_d = final_v;
          k_d   = k_q + KW'(1);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky saturation flag; a new saturation beats a simultaneous clear.
  always_comb begin
    sat_flag_d = sat_clr ? 1'b0 : sat_flag_q;
    if (sat_set) begin
      sat_flag_d = 1'b1;
    end
  end

  // State registers; reset abandons any partial sample and clears the history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      for (int j = 0; j < N - 1; j++) begin
        hist_q[j] <= '0;
      end
      x_out_q     <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      hist_q      <= hist_d;
      x_out_q     <= x_out_d;
      out_valid_q <= out_valid_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_fir_inverse.sv
// Bench for fir_inverse: directed scenarios plus random samples against a recursion model.
// Latency: expects out_valid 3 cycles after each accept, accepts 5 cycles apart at full rate.
// Backpressure: holds out_ready low and checks the result stays put with nothing extra captured.
module tb_fir_inverse;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int YW = 16;
  localparam int AW = 18;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [YW-1:0] y_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x_out;
  logic                 sat_clr;
  logic                 sat_flag;

  fir_inverse #(.N(N), .DW(DW), .YW(YW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out),
    .sat_clr(sat_clr), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: x[n] = clamp(y[n] - 2x[n-1] - 3x[n-2] - 4x[n-3]), history holds clamped values.
  int m_hist[3];
  bit m_sat;

  function automatic int model_step(input int y);
    int v;
    v = y - 2 * m_hist[0] - 3 * m_hist[1] - 4 * m_hist[2];
    if (v > 127) begin
      v = 127;
      m_sat = 1'b1;
    end else if (v < -128) begin
      v = -128;
      m_sat = 1'b1;
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = v;
    return v;
  endfunction

  function automatic void model_clear();
    m_hist[0] = 0;
    m_hist[1] = 0;
    m_hist[2] = 0;
    m_sat = 1'b0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    model_clear();
  endtask

  // One sample: accept, measure latency, optionally stall the output for 'hold' cycles.
  task automatic run_sample(input int y, input int hold, input string tag);
    int lat;
    int exp_x;
    int got;
    for (int w = 0; w < 20 && !in_ready; w++) tick();
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    y_in      = YW'(y);
    tick();
    in_valid  = 1'b0;
    exp_x     = model_step(y);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    got = int'(x_out);
    chk({tag, "_x_out"}, got, exp_x);
    chk({tag, "_sat_flag"}, int'(sat_flag), int'(m_sat));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_valid"}, int'(out_valid), 1);
      chk({tag, "_hold_x"}, int'(x_out), exp_x);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_drop_valid"}, int'(out_valid), 0);
    chk({tag, "_idle_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int ys[8];
    longint t_acc[8];
    int lat;
    int exp_x;
    int held_x;

    rst       = 1'b1;
    in_valid  = 1'b0;
    y_in      = '0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    model_clear();

    // Reset state
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_x_out", int'(x_out), 0);
    chk("rst_sat_flag", int'(sat_flag), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Impulse: y = 1,2,3,4 -> x = 1,0,0,0
    run_sample(1, 0, "imp0");
    run_sample(2, 0, "imp1");
    run_sample(3, 0, "imp2");
    run_sample(4, 0, "imp3");
    chk("imp_x_last", int'(x_out), 0);

    // Mixed: FIR of 10,-5,127,-128
    do_reset();
    run_sample(10, 0, "mix0");
    run_sample(15, 0, "mix1");
    run_sample(147, 0, "mix2");
    run_sample(151, 0, "mix3");
    chk("mix_x_last", int'(x_out), -128);
    chk("mix_sat", int'(sat_flag), 0);

    // Saturation high then low, then clear
    do_reset();
    run_sample(300, 0, "sat_hi");
    chk("sat_hi_x", int'(x_out), 127);
    run_sample(0, 0, "sat_lo");
    chk("sat_lo_x", int'(x_out), -128);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    m_sat   = 1'b0;
    chk("sat_clr", int'(sat_flag), 0);

    // Backpressure: stall 10 cycles while pulsing in_valid
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    y_in      = YW'(42);
    tick();
    in_valid  = 1'b0;
    exp_x     = model_step(42);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp_latency", lat, 3);
    held_x = int'(x_out);
    chk("bp_x", held_x, exp_x);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      y_in     = YW'(99);
      tick();
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_x", int'(x_out), held_x);
      chk("bp_hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_no_extra", int'(out_valid), 0);
    end

    // Reset mid-MAC, then history must be clear
    in_valid = 1'b1;
    y_in     = YW'(77);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    chk("midrst_release_ready", int'(in_ready), 1);
    run_sample(5, 0, "after_rst");
    chk("after_rst_x", int'(x_out), 5);

    // Throughput: in_valid and out_ready held high for 8 random samples
    do_reset();
    for (int i = 0; i < 8; i++) ys[i] = int'($urandom_range(0, 600)) - 300;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int w = 0; w < 20 && !in_ready; w++) tick();
      chk("tp_in_ready", int'(in_ready), 1);
      y_in = YW'(ys[i]);
      @(posedge clk);
      t_acc[i] = $time;
      #1;
      exp_x = model_step(ys[i]);
      lat = 0;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      if (i == 7) in_valid = 1'b0;
      chk("tp_latency", lat, 3);
      chk("tp_x", int'(x_out), exp_x);
      chk("tp_sat", int'(sat_flag), int'(m_sat));
      if (i > 0) chk("tp_spacing", int'(t_acc[i] - t_acc[i-1]), 50);
    end
    tick();
    tick();
    chk("tp_drained", int'(out_valid), 0);

    // Random samples with random output stalls
    for (int i = 0; i < 12; i++) begin
      run_sample(int'($urandom_range(0, 3000)) - 1500, int'($urandom_range(0, 3)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
